// File: rtl/alu_pkg.sv
// Shared definitions for the iterative WISC execute-stage ALU:
// operation codes, flag bit positions and the controller state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_XOR    = 4'b0010;
  localparam logic [3:0] ALU_RED    = 4'b0011;
  localparam logic [3:0] ALU_SLL    = 4'b0100;
  localparam logic [3:0] ALU_SRA    = 4'b0101;
  localparam logic [3:0] ALU_ROR    = 4'b0110;
  localparam logic [3:0] ALU_PADDSB = 4'b0111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sat_add.sv
// Signed W-bit adder/subtractor with saturation to the signed range and an
// overflow indication (set whenever the result had to be clamped).
module alu_sat_add #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  // Clamp a (W+1)-bit exact result into W bits.
  function automatic logic signed [W-1:0] saturate(input logic signed [W:0] x);
    logic signed [W-1:0] r;
    if (x[W] != x[W-1]) begin
      r = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      r = x[W-1:0];
    end
    return r;
  endfunction

  logic signed [W:0] a_ext;
  logic signed [W:0] b_ext;
  logic signed [W:0] raw;

  // One guard bit makes the add/sub exact, so overflow is a sign disagreement.
  assign a_ext = {a[W-1], a};
  assign b_ext = {b[W-1], b};
  assign raw   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
  assign sum   = saturate(raw);
  assign ovf   = raw[W] ^ raw[W-1];

endmodule

// File: rtl/alu_iter.sv
// Handshaked WIDTH-bit ALU with saturating ADD/SUB, XOR, byte reduction,
// nibble-wise saturating add and shifts/rotates.
// Build option ALU_ITER_BARREL_SHIFT_EN: when defined, shifts use a
// single-cycle barrel shifter; otherwise they shift one bit per cycle.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] op1,
  input  logic signed [WIDTH-1:0] op2,
  input  logic [3:0]              aluop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        alu_out,
  output logic [2:0]              flag
);

  // Sum of every byte of both operands, each byte signed; wraps within WIDTH.
  function automatic logic [WIDTH-1:0] red_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] acc;
    logic signed [7:0]       bt;
    acc = '0;
    for (int i = 0; i < WIDTH/8; i++) begin
      bt  = a[8*i +: 8];
      acc = acc + WIDTH'(bt);
      bt  = b[8*i +: 8];
      acc = acc + WIDTH'(bt);
    end
    return acc;
  endfunction

`ifdef ALU_ITER_BARREL_SHIFT_EN
  // Log-depth shifter: stage k moves the value by 2**k when amount bit k is set.
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] x,
                                              input logic [SHAMT_W-1:0] s,
                                              input logic [3:0] op);
    logic [WIDTH-1:0] v;
    v = x;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (s[k]) begin
        case (op)
          ALU_SLL: v = v << (2**k);
          ALU_SRA: v = WIDTH'($signed(v) >>> (2**k));
          default: v = (v >> (2**k)) | (v << (WIDTH - 2**k));
        endcase
      end
    end
    return v;
  endfunction
`else
  // Single-bit step of the iterative shifter.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] x,
                                              input logic [3:0] op);
    logic [WIDTH-1:0] r;
    case (op)
      ALU_SLL: r = {x[WIDTH-2:0], 1'b0};
      ALU_SRA: r = {x[WIDTH-1], x[WIDTH-1:1]};
      default: r = {x[0], x[WIDTH-1:1]};
    endcase
    return r;
  endfunction
`endif

  state_t                 state_p1;
  state_t                 state_d;
  logic                   accept_p0;
  logic [SHAMT_W-1:0]     amt_p0;
  logic [WIDTH-1:0]       res_p0;
  logic                   upd_z_p0;
  logic                   upd_vn_p0;
  logic                   ovf_p0;
  logic                   go_shift_p0;
  logic signed [WIDTH-1:0] sum_p0;
  logic                   sum_ovf_p0;
  logic [WIDTH-1:0]       padd_p0;
  logic [WIDTH/4-1:0]     padd_ovf_unused;

`ifndef ALU_ITER_BARREL_SHIFT_EN
  logic [SHAMT_W-1:0]     cnt_p1;
  logic [WIDTH-1:0]       shreg_p1;
  logic [3:0]             shop_p1;
  logic [WIDTH-1:0]       shstep;

  assign shstep = shift1(shreg_p1, shop_p1);
`endif

  assign amt_p0    = op2[SHAMT_W-1:0];
  assign accept_p0 = in_valid && in_ready;

  // ---- p0: issue stage, operands evaluated combinationally at accept ----
  alu_sat_add #(.W(WIDTH)) u_addsub (
    .a   (op1),
    .b   (op2),
    .sub (aluop == ALU_SUB),
    .sum (sum_p0),
    .ovf (sum_ovf_p0)
  );

  for (genvar g = 0; g < WIDTH/4; g++) begin : g_nib
    alu_sat_add #(.W(4)) u_nib (
      .a   (op1[4*g +: 4]),
      .b   (op2[4*g +: 4]),
      .sub (1'b0),
      .sum (padd_p0[4*g +: 4]),
      .ovf (padd_ovf_unused[g])
    );
  end

  // Select the issue-time result and which flags it is allowed to write.
  always_comb begin
    res_p0      = '0;
    upd_z_p0    = 1'b0;
    upd_vn_p0   = 1'b0;
    ovf_p0      = 1'b0;
    go_shift_p0 = 1'b0;
    case (aluop)
      ALU_ADD, ALU_SUB: begin
        res_p0    = sum_p0;
        upd_z_p0  = 1'b1;
        upd_vn_p0 = 1'b1;
        ovf_p0    = sum_ovf_p0;
      end
      ALU_XOR: begin
        res_p0   = op1 ^ op2;
        upd_z_p0 = 1'b1;
      end
      ALU_RED:    res_p0 = red_sum(op1, op2);
      ALU_SLL, ALU_SRA, ALU_ROR: begin
        upd_z_p0 = 1'b1;
`ifdef ALU_ITER_BARREL_SHIFT_EN
        res_p0 = barrel(op1, amt_p0, aluop);
`else
        // A zero-amount shift is finished at issue; otherwise iterate.
        res_p0      = op1;
        go_shift_p0 = (amt_p0 != '0);
`endif
      end
      ALU_PADDSB: res_p0 = padd_p0;
      default:    ;
    endcase
  end

  // ---- p1: controller state and registered result/flags ----
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p1 <= ST_IDLE;
    else     state_p1 <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_p1;
    case (state_p1)
      ST_IDLE: if (accept_p0) state_d = go_shift_p0 ? ST_SHIFT : ST_DONE;
      ST_SHIFT: begin
`ifndef ALU_ITER_BARREL_SHIFT_EN
        if (cnt_p1 == SHAMT_W'(1)) state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (accept_p0)      state_d = go_shift_p0 ? ST_SHIFT : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs; a draining result frees the input in the same cycle.
  always_comb begin
    in_ready  = (state_p1 == ST_IDLE) || ((state_p1 == ST_DONE) && out_ready);
    out_valid = (state_p1 == ST_DONE);
  end

  // Result, flags and shift counter; results held untouched while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out <= '0;
      flag    <= '0;
`ifndef ALU_ITER_BARREL_SHIFT_EN
      cnt_p1  <= '0;
`endif
    end else if (accept_p0) begin
      if (!go_shift_p0) begin
        alu_out <= res_p0;
        if (upd_z_p0) flag[FLAG_Z] <= (res_p0 == '0);
        if (upd_vn_p0) begin
          flag[FLAG_V] <= ovf_p0;
          flag[FLAG_N] <= res_p0[WIDTH-1];
        end
      end
`ifndef ALU_ITER_BARREL_SHIFT_EN
      cnt_p1 <= amt_p0;
    end else if (state_p1 == ST_SHIFT) begin
      cnt_p1 <= cnt_p1 - SHAMT_W'(1);
      if (cnt_p1 == SHAMT_W'(1)) begin
        alu_out      <= shstep;
        flag[FLAG_Z] <= (shstep == '0);
      end
`endif
    end
  end

`ifndef ALU_ITER_BARREL_SHIFT_EN
  // Shift working register and captured opcode; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      shreg_p1 <= op1;
      shop_p1  <= aluop;
    end else if (state_p1 == ST_SHIFT) begin
      shreg_p1 <= shstep;
    end
  end
`endif

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
Parametrised, handshaked successor to the single-cycle 16-bit ALU, for the WISC execute stage.
- Same 4-bit aluop encoding and Z/V/N flag semantics as the existing ALU.
- Generalised in WIDTH, with signed saturating ADD/SUB.
- Shifts and rotates run on a multi-cycle iterative shifter.
- Valid/ready on both the input and output sides, so the pipeline can stall on long shifts.

Parameters:
- WIDTH, 16: datapath width; must be a multiple of 8 and at least 8.
- SHAMT_W, 4: shift-amount width; equals log2(WIDTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and aluop are valid.
- in_ready  out  1  block can accept an operation.
- op1  in  WIDTH  operand A, signed.
- op2  in  WIDTH  operand B, signed; op2[SHAMT_W-1:0] is the shift amount.
- aluop  in  4  operation code.
- out_valid  out  1  alu_out is valid.
- out_ready  in  1  consumer accepts the result.
- alu_out  out  WIDTH  registered result.
- flag  out  3  registered flags {Z,V,N}: flag[2]=Z, flag[1]=V, flag[0]=N.

Behaviour:
- Reset (async, immediate): state=IDLE, alu_out=0, out_valid=0, flag=3'b000, shift counter=0. Reset mid-SHIFT aborts the operation and no result is produced.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back accepts are allowed in the same cycle as a result drain.
  - In DONE, out_valid=1. alu_out and out_valid hold stable while out_ready=0.
  - DONE && out_ready with no new accept -> IDLE.
- FSM: IDLE -> (accept) -> SHIFT or DONE; SHIFT -> DONE; DONE -> IDLE or DONE (drain plus simultaneous accept).
- Latency:
  - Non-shift ops, and shifts with amount 0: accept at cycle N, out_valid at N+1.
  - Shift ops with amount s>0: enter SHIFT, shift one bit per cycle, out_valid at N+1+s.
- Opcodes:
  - 0000 ADD: signed saturating; clamps to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
  - 0001 SUB: signed saturating, same clamps.
  - 0010 XOR.
  - 0011 RED: sum of all bytes of op1 and op2, each taken as signed 8-bit; result sign-extended to WIDTH.
  - 0100 SLL: zero fill.
  - 0101 SRA: sign fill.
  - 0110 ROR: rotate right.
  - 0111 PADDSB: independent signed saturating add per 4-bit nibble.
  - 1xxx: illegal; result 0, no flag update, 1-cycle latency.
- Flags (written on the cycle the result enters DONE):
  - ADD/SUB: update Z, V, N. V=1 iff saturation occurred; N = sign of the saturated result.
  - XOR/SLL/SRA/ROR: update Z only; V and N hold.
  - RED/PADDSB: no flag update.
- Operands are captured at accept; changes to op1, op2 or aluop after accept have no effect.

Optional Feature:
- Macro: ALU_ITER_BARREL_SHIFT_EN.
- Defined: SLL/SRA/ROR use a combinational log-depth barrel shifter and complete in 1 cycle like the other ops; the SHIFT state and counter are not built.
- Undefined: iterative shifter as described above.
- Results and flags are identical in both builds; only latency differs.

Decomposition:
- Package alu_pkg: aluop localparams (ALU_ADD .. ALU_PADDSB), flag bit indices FLAG_Z=2, FLAG_V=1, FLAG_N=0, and the FSM state encoding.
- Sub-module alu_sat_add #(W): signed W-bit add/sub with saturation and overflow output.
  - One instance at W=WIDTH serves ADD/SUB.
  - WIDTH/4 instances at W=4 serve PADDSB.

Test Plan:
1. ADD 0x7FFF+0x0001, flag previously 000 -> alu_out=0x7FFF, flag=3'b010, out_valid at N+1.
2. SUB 0x0005-0x0005 -> alu_out=0x0000, flag=3'b100; then SUB 0x0000-0x0001 -> 0xFFFF, flag=3'b001.
3. SLL 0x0001 by 3 after a V-setting ADD -> alu_out=0x0008 at N+4, flag=3'b010 (Z=0 written, V/N held); SRA 0x8000 by 15 -> 0xFFFF at N+16; ROR 0x0001 by 1 -> 0x8000.
4. PADDSB 0x7878+0x1111 -> 0x7979, flags unchanged; RED 0x0102+0x0304 -> 0x000A.
5. Backpressure: out_ready=0 for 5 cycles -> alu_out and out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 -> next op accepted in the same cycle.
6. Assert rst during SHIFT (SRA by 10, 4 cycles in) -> out_valid=0 and flag=000 immediately; with rst high, no output appears; the next op after rst deasserts completes normally.
